// File: rtl/leaf_uplink_nic_if.sv
// Bundles the local request/consumer, spine link and counter signals of one leaf NIC.
// No storage; pure wiring between the leaf NIC and its environment.
// Backpressure: tx_ready/rx_ready handshakes locally; spine side is valid-only plus up_full.
interface leaf_uplink_nic_if #(
    parameter int DWIDTH = 16,
    parameter int CNT_W  = 8
);
    // local request side
    logic              tx_valid;
    logic              tx_ready;
    logic [3:0]        tx_dest_group;
    logic [1:0]        tx_dest_leaf;
    logic [9:0]        tx_payload;
    // toward the spine port input
    logic [DWIDTH-1:0] up_out_data;
    logic              up_out_valid;
    logic              up_full;
    // from the spine port output
    logic [DWIDTH-1:0] dn_in_data;
    logic              dn_in_valid;
    // local consumer side
    logic              rx_valid;
    logic              rx_ready;
    logic [9:0]        rx_payload;
    logic [3:0]        rx_src_group;
    // statistics
    logic              cnt_clr;
    logic [CNT_W-1:0]  misroute_cnt;
    logic [CNT_W-1:0]  overflow_cnt;
    logic              rx_overflow;

    // environment view: local client, consumer and spine port
    modport master (
        output tx_valid, tx_dest_group, tx_dest_leaf, tx_payload,
        output up_full, dn_in_data, dn_in_valid, rx_ready, cnt_clr,
        input  tx_ready, up_out_data, up_out_valid,
        input  rx_valid, rx_payload, rx_src_group,
        input  misroute_cnt, overflow_cnt, rx_overflow
    );

    // NIC view
    modport slave (
        input  tx_valid, tx_dest_group, tx_dest_leaf, tx_payload,
        input  up_full, dn_in_data, dn_in_valid, rx_ready, cnt_clr,
        output tx_ready, up_out_data, up_out_valid,
        output rx_valid, rx_payload, rx_src_group,
        output misroute_cnt, overflow_cnt, rx_overflow
    );
endinterface

// File: rtl/leaf_uplink_nic.sv
// Generic show-ahead synchronous FIFO with extra-bit pointers.
// Latency: a pushed word is visible at head_dat_o the cycle after the push.
// Backpressure: push ignored when full unless popping in the same cycle; pop ignored when empty.
module sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [AW:0]      count_o
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             full, empty, do_push, do_pop;

    assign count_o    = wptr_q - rptr_q;
    assign full       = (count_o == FULL_CNT);
    assign empty      = (count_o == '0);
    assign do_pop     = pop_i && !empty;
    // at full, a same-cycle pop frees the slot the write lands in
    assign do_push    = push_i && (!full || do_pop);
    assign head_dat_o = mem_q[rptr_q[AW-1:0]];

    // pointer update; the MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // storage write, contents need no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_dat_i;
    end
endmodule

// Leaf NIC: formats local requests into flits for the spine, filters and buffers flits from it.
// Latency: TX request to up_out_valid 2 cycles; RX flit to rx_valid 1 cycle.
// Backpressure: TX waits on up_full; RX cannot stall and drops/counts misroutes and overflows.
module leaf_uplink_nic #(
    parameter logic [3:0] GROUP_ID   = 4'b0100,
    parameter logic [1:0] LEAF_ID    = 2'd0,
    parameter int         DWIDTH     = 16,
    parameter int         FIFO_DEPTH = 8,
    parameter int         CNT_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    leaf_uplink_nic_if.slave   bus
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
    localparam int          RXW      = 14;  // dest leaf is implied by the filter, so not stored

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_BLOCKED} tx_state_e;

    // ---------------- TX path ----------------
    tx_state_e         state_q, state_d;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [AW:0]       tx_cnt;
    logic [DWIDTH-1:0] tx_flit, tx_head;
    logic              up_out_valid_q;
    logic [DWIDTH-1:0] up_out_data_q;

    assign tx_full     = (tx_cnt == FULL_CNT);
    assign tx_empty    = (tx_cnt == '0);
    assign bus.tx_ready = !tx_full;
    assign tx_push     = bus.tx_valid && !tx_full;
    assign tx_flit     = {bus.tx_dest_group, bus.tx_dest_leaf, bus.tx_payload};

    sync_fifo #(.WIDTH(DWIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (tx_push),
        .push_dat_i (tx_flit),
        .pop_i      (tx_pop),
        .head_dat_o (tx_head),
        .count_o    (tx_cnt)
    );

    // TX FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // TX FSM next state; IDLE leaves on the push itself so the first pop is the next cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (tx_push || !tx_empty) state_d = ST_SEND;
            ST_SEND: begin
                if (bus.up_full)                       state_d = ST_BLOCKED;
                else if (tx_push || (tx_cnt > ONE_CNT)) state_d = ST_SEND;
                else                                   state_d = ST_IDLE;
            end
            ST_BLOCKED: if (!bus.up_full) state_d = ST_SEND;
            default:    state_d = ST_IDLE;
        endcase
    end

    // TX FSM output: pop only in SEND while the spine input has room
    always_comb begin
        tx_pop = (state_q == ST_SEND) && !bus.up_full && !tx_empty;
    end

    // output register: valid pulses once per popped flit, data holds between flits
    always_ff @(posedge clk) begin
        if (reset) begin
            up_out_valid_q <= 1'b0;
            up_out_data_q  <= '0;
        end else begin
            up_out_valid_q <= tx_pop;
            if (tx_pop) up_out_data_q <= tx_head;
        end
    end

    assign bus.up_out_valid = up_out_valid_q;
    assign bus.up_out_data  = up_out_data_q;

    // ---------------- RX path ----------------
    logic             rx_match, rx_push, rx_pop, rx_full, rx_empty;
    logic             misroute_ev, overflow_ev;
    logic [AW:0]      rx_cnt;
    logic [RXW-1:0]   rx_head;
    logic [CNT_W-1:0] misroute_cnt_q, misroute_cnt_d;
    logic [CNT_W-1:0] overflow_cnt_q, overflow_cnt_d;
    logic             rx_overflow_q, rx_overflow_d;

    assign rx_full     = (rx_cnt == FULL_CNT);
    assign rx_empty    = (rx_cnt == '0);
    assign rx_match    = (bus.dn_in_data[15:12] == GROUP_ID) && (bus.dn_in_data[11:10] == LEAF_ID);
    assign rx_pop      = !rx_empty && bus.rx_ready;
    assign rx_push     = bus.dn_in_valid && rx_match && (!rx_full || rx_pop);
    assign misroute_ev = bus.dn_in_valid && !rx_match;
    assign overflow_ev = bus.dn_in_valid && rx_match && rx_full && !rx_pop;

    sync_fifo #(.WIDTH(RXW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (rx_push),
        .push_dat_i ({bus.dn_in_data[15:12], bus.dn_in_data[9:0]}),
        .pop_i      (rx_pop),
        .head_dat_o (rx_head),
        .count_o    (rx_cnt)
    );

    assign bus.rx_valid     = !rx_empty;
    assign bus.rx_src_group = rx_head[13:10];
    assign bus.rx_payload   = rx_head[9:0];

    // drop statistics: saturating counters and sticky flag, clear beats a same-cycle drop
    always_comb begin
        misroute_cnt_d = misroute_cnt_q;
        overflow_cnt_d = overflow_cnt_q;
        rx_overflow_d  = rx_overflow_q | overflow_ev;
        if (misroute_ev && (misroute_cnt_q != '1)) misroute_cnt_d = misroute_cnt_q + 1'b1;
        if (overflow_ev && (overflow_cnt_q != '1)) overflow_cnt_d = overflow_cnt_q + 1'b1;
        if (bus.cnt_clr) begin
            misroute_cnt_d = '0;
            overflow_cnt_d = '0;
            rx_overflow_d  = 1'b0;
        end
    end

    // drop statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            misroute_cnt_q <= '0;
            overflow_cnt_q <= '0;
            rx_overflow_q  <= 1'b0;
        end else begin
            misroute_cnt_q <= misroute_cnt_d;
            overflow_cnt_q <= overflow_cnt_d;
            rx_overflow_q  <= rx_overflow_d;
        end
    end

    assign bus.misroute_cnt = misroute_cnt_q;
    assign bus.overflow_cnt = overflow_cnt_q;
    assign bus.rx_overflow  = rx_overflow_q;
endmodule

// File: tb/tb_leaf_uplink_nic.sv
module tb_leaf_uplink_nic;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    leaf_uplink_nic_if #(.DWIDTH(16), .CNT_W(8)) bus ();

    leaf_uplink_nic #(
        .GROUP_ID(4'b0100), .LEAF_ID(2'd0), .DWIDTH(16), .FIFO_DEPTH(8), .CNT_W(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.tx_valid = 1'b0; bus.tx_dest_group = 4'h0; bus.tx_dest_leaf = 2'd0; bus.tx_payload = 10'h0;
        bus.up_full = 1'b0; bus.dn_in_valid = 1'b0; bus.dn_in_data = 16'h0;
        bus.rx_ready = 1'b0; bus.cnt_clr = 1'b0;
    endtask

    // one cycle of inputs and the outputs expected just after the closing edge
    typedef struct packed {
        logic       txv;  logic [3:0] g;   logic [1:0] l;   logic [9:0] pl; logic upf;
        logic       dnv;  logic [15:0] dnd; logic rxr;      logic clr;
        logic       e_txr; logic e_upv;    logic [15:0] e_upd;
        logic       e_rxv; logic [9:0] e_rxp; logic [7:0] e_mis; logic [7:0] e_ovf;
    } vec_t;

    localparam int NV = 16;
    vec_t tv [NV];

    initial begin
        //          txv  g     l     pl      upf   dnv   dnd       rxr   clr   txr   upv   upd       rxv   rxp     mis   ovf
        tv[0]  = '{1'b1, 4'h4, 2'd1, 10'h155, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 10'h000, 8'd0, 8'd0};
        tv[1]  = '{1'b0, 4'h0, 2'd0, 10'h000, 1'b0, 1'b1, 16'h4555, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4555, 1'b0, 10'h000, 8'd1, 8'd0};
        tv[2]  = '{1'b0, 4'h0, 2'd0, 10'h000, 1'b0, 1'b1, 16'h4055, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4555, 1'b1, 10'h055, 8'd1, 8'd0};
        tv[3]  = '{1'b0, 4'h0, 2'd0, 10'h000, 1'b0, 1'b1, 16'h5055, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4555, 1'b1, 10'h055, 8'd2, 8'd0};
        tv[4]  = '{1'b0, 4'h0, 2'd0, 10'h000, 1'b0, 1'b1, 16'h4155, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4555, 1'b1, 10'h155, 8'd2, 8'd0};
        tv[5]  = '{1'b0, 4'h0, 2'd0, 10'h000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4555, 1'b0, 10'h000, 8'd2, 8'd0};
        tv[6]  = '{1'b1, 4'h2, 2'd3, 10'h3FF, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h4555, 1'b0, 10'h000, 8'd2, 8'd0};
        tv[7]  = '{1'b1, 4'hF, 2'd0, 10'h001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2FFF, 1'b0, 10'h000, 8'd2, 8'd0};
        tv[8]  = '{1'b0, 4'h0, 2'd0, 10'h000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'hF001, 1'b0, 10'h000, 8'd2, 8'd0};
        tv[9]  = '{1'b0, 4'h0, 2'd0, 10'h000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'hF001, 1'b0, 10'h000, 8'd2, 8'd0};
        tv[10] = '{1'b1, 4'h1, 2'd2, 10'h2AA, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'hF001, 1'b0, 10'h000, 8'd2, 8'd0};
        tv[11] = '{1'b0, 4'h0, 2'd0, 10'h000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'hF001, 1'b0, 10'h000, 8'd2, 8'd0};
        tv[12] = '{1'b0, 4'h0, 2'd0, 10'h000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'hF001, 1'b0, 10'h000, 8'd2, 8'd0};
        tv[13] = '{1'b0, 4'h0, 2'd0, 10'h000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'hF001, 1'b0, 10'h000, 8'd2, 8'd0};
        tv[14] = '{1'b0, 4'h0, 2'd0, 10'h000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1AAA, 1'b0, 10'h000, 8'd2, 8'd0};
        tv[15] = '{1'b0, 4'h0, 2'd0, 10'h000, 1'b0, 1'b1, 16'h5055, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1AAA, 1'b0, 10'h000, 8'd0, 8'd0};
    end

    initial begin : main
        logic [15:0] exp_q [$];
        logic [23:0] upf_pat;
        logic        upf_cur;
        int          got, first_c, last_c;

        // ---- reset state ----
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst up_valid", 32'(bus.up_out_valid), 32'd0);
        chk("rst up_data",  32'(bus.up_out_data),  32'd0);
        chk("rst rx_valid", 32'(bus.rx_valid),     32'd0);
        chk("rst tx_ready", 32'(bus.tx_ready),     32'd1);
        chk("rst misroute", 32'(bus.misroute_cnt), 32'd0);
        chk("rst overflow", 32'(bus.overflow_cnt), 32'd0);
        chk("rst sticky",   32'(bus.rx_overflow),  32'd0);
        reset = 1'b0;

        // ---- table-driven vectors ----
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.tx_valid = tv[i].txv; bus.tx_dest_group = tv[i].g; bus.tx_dest_leaf = tv[i].l;
            bus.tx_payload = tv[i].pl; bus.up_full = tv[i].upf; bus.dn_in_valid = tv[i].dnv;
            bus.dn_in_data = tv[i].dnd; bus.rx_ready = tv[i].rxr; bus.cnt_clr = tv[i].clr;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d tx_ready", i), 32'(bus.tx_ready),     32'(tv[i].e_txr));
            chk($sformatf("v%0d up_valid", i), 32'(bus.up_out_valid), 32'(tv[i].e_upv));
            chk($sformatf("v%0d up_data", i),  32'(bus.up_out_data),  32'(tv[i].e_upd));
            chk($sformatf("v%0d rx_valid", i), 32'(bus.rx_valid),     32'(tv[i].e_rxv));
            if (tv[i].e_rxv)
                chk($sformatf("v%0d rx_payload", i), 32'(bus.rx_payload), 32'(tv[i].e_rxp));
            chk($sformatf("v%0d misroute", i), 32'(bus.misroute_cnt), 32'(tv[i].e_mis));
            chk($sformatf("v%0d overflow", i), 32'(bus.overflow_cnt), 32'(tv[i].e_ovf));
        end

        // ---- fill TX while blocked, 9th refused, then drain in order on consecutive cycles ----
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            idle_inputs();
            bus.up_full = 1'b1; bus.tx_valid = 1'b1;
            bus.tx_dest_group = 4'h3; bus.tx_dest_leaf = 2'd2; bus.tx_payload = 10'(i * 7 + 1);
            chk($sformatf("txfull ready%0d", i), 32'(bus.tx_ready), (i < 8) ? 32'd1 : 32'd0);
            if (i < 8) exp_q.push_back({4'h3, 2'd2, 10'(i * 7 + 1)});
            @(posedge clk);
            #1;
            chk($sformatf("txfull blocked_valid%0d", i), 32'(bus.up_out_valid), 32'd0);
        end
        got = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            idle_inputs();
            @(posedge clk);
            #1;
            if (bus.up_out_valid) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
                if (exp_q.size() == 0) chk("txfull extra_flit", 32'(bus.up_out_data), 32'hFFFF_FFFF);
                else chk($sformatf("txfull data%0d", got), 32'(bus.up_out_data), 32'(exp_q.pop_front()));
            end
        end
        chk("txfull count", 32'(got), 32'd8);
        chk("txfull consecutive", 32'(last_c - first_c), 32'd7);
        exp_q.delete();

        // ---- up_full toggling during a burst: no loss, no duplicate, no send after up_full=1 ----
        upf_pat = 24'b0000_0011_0101_1001_1011_0100;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            idle_inputs();
            upf_cur = (c < 24) ? upf_pat[c] : 1'b0;
            bus.up_full = upf_cur;
            if (c < 6) begin
                bus.tx_valid = 1'b1; bus.tx_dest_group = 4'hA; bus.tx_dest_leaf = 2'd1;
                bus.tx_payload = 10'(10'h100 + c);
                exp_q.push_back({4'hA, 2'd1, 10'(10'h100 + c)});
            end
            @(posedge clk);
            #1;
            if (bus.up_out_valid) begin
                got++;
                chk($sformatf("burst sent_while_full c%0d", c), 32'(upf_cur), 32'd0);
                if (exp_q.size() == 0) chk("burst duplicate", 32'(bus.up_out_data), 32'hFFFF_FFFF);
                else chk($sformatf("burst data c%0d", c), 32'(bus.up_out_data), 32'(exp_q.pop_front()));
            end
        end
        chk("burst count", 32'(got), 32'd6);
        chk("burst leftover", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        // ---- RX overflow: 8 fill, 3 dropped, 9th accepted with a same-cycle pop ----
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            idle_inputs();
            bus.dn_in_valid = 1'b1; bus.dn_in_data = {4'h4, 2'd0, 10'(i)};
            @(posedge clk);
            #1;
            chk($sformatf("rxfill valid%0d", i), 32'(bus.rx_valid), 32'd1);
        end
        chk("rxfill overflow", 32'(bus.overflow_cnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_inputs();
            bus.dn_in_valid = 1'b1; bus.dn_in_data = {4'h4, 2'd0, 10'(10'h200 + i)};
            @(posedge clk);
            #1;
            chk($sformatf("rxovf cnt%0d", i), 32'(bus.overflow_cnt), 32'(i + 1));
            chk($sformatf("rxovf sticky%0d", i), 32'(bus.rx_overflow), 32'd1);
        end
        @(negedge clk);
        idle_inputs();
        bus.dn_in_valid = 1'b1; bus.dn_in_data = {4'h4, 2'd0, 10'h3C3}; bus.rx_ready = 1'b1;
        chk("rxpushpop head", 32'(bus.rx_payload), 32'd0);
        @(posedge clk);
        #1;
        chk("rxpushpop overflow", 32'(bus.overflow_cnt), 32'd3);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            idle_inputs();
            bus.rx_ready = 1'b1;
            chk($sformatf("rxdrain valid%0d", k), 32'(bus.rx_valid), 32'd1);
            chk($sformatf("rxdrain payload%0d", k), 32'(bus.rx_payload), (k < 7) ? 32'(k + 1) : 32'h3C3);
            chk($sformatf("rxdrain group%0d", k), 32'(bus.rx_src_group), 32'h4);
            @(posedge clk);
        end
        #1;
        chk("rxdrain empty", 32'(bus.rx_valid), 32'd0);
        chk("rxdrain misroute", 32'(bus.misroute_cnt), 32'd0);

        // ---- misroute saturation, then clear ----
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            idle_inputs();
            bus.dn_in_valid = 1'b1; bus.dn_in_data = 16'h5055;
            @(posedge clk);
        end
        #1;
        chk("sat misroute", 32'(bus.misroute_cnt), 32'd255);
        chk("sat overflow", 32'(bus.overflow_cnt), 32'd3);
        chk("sat sticky",   32'(bus.rx_overflow),  32'd1);
        @(negedge clk);
        idle_inputs();
        bus.cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("clr misroute", 32'(bus.misroute_cnt), 32'd0);
        chk("clr overflow", 32'(bus.overflow_cnt), 32'd0);
        chk("clr sticky",   32'(bus.rx_overflow),  32'd0);

        // ---- reset in the middle of a TX burst ----
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            idle_inputs();
            bus.tx_valid = 1'b1; bus.tx_dest_group = 4'h7; bus.tx_dest_leaf = 2'd3;
            bus.tx_payload = 10'(10'h050 + c);
            if (c == 0) begin bus.dn_in_valid = 1'b1; bus.dn_in_data = 16'h4011; end
            @(posedge clk);
            #1;
        end
        chk("rstburst inflight_valid", 32'(bus.up_out_valid), 32'd1);
        chk("rstburst inflight_data",  32'(bus.up_out_data),  32'({4'h7, 2'd3, 10'h053}));
        chk("rstburst rx_before",      32'(bus.rx_valid),     32'd1);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstburst up_valid", 32'(bus.up_out_valid), 32'd0);
        chk("rstburst up_data",  32'(bus.up_out_data),  32'd0);
        chk("rstburst tx_ready", 32'(bus.tx_ready),     32'd1);
        chk("rstburst rx_valid", 32'(bus.rx_valid),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rstburst quiet%0d", c), 32'(bus.up_out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
